// File: rtl/sdram_fifo_sched_if.sv
// Burst request/acknowledge channel between the FIFO scheduler and the SDRAM core.
// The scheduler (master) drives req/addr; the core (slave) answers one ack per beat.
interface sdram_fifo_sched_if #(
  parameter int unsigned ADDR_WIDTH = 24
);
  logic                  sdram_wr_req;
  logic [ADDR_WIDTH-1:0] sdram_wr_addr;
  logic                  sdram_wr_ack;
  logic                  sdram_rd_req;
  logic [ADDR_WIDTH-1:0] sdram_rd_addr;
  logic                  sdram_rd_ack;

  modport master (
    output sdram_wr_req,
    output sdram_wr_addr,
    input  sdram_wr_ack,
    output sdram_rd_req,
    output sdram_rd_addr,
    input  sdram_rd_ack
  );

  modport slave (
    input  sdram_wr_req,
    input  sdram_wr_addr,
    output sdram_wr_ack,
    input  sdram_rd_req,
    input  sdram_rd_addr,
    output sdram_rd_ack
  );
endinterface

// File: rtl/sdram_fifo_sched.sv
// Burst scheduler moving fixed-length bursts between user FIFOs and an SDRAM ring region.
// Define SDRAM_WR_PRIORITY_EN for fixed write priority; default arbitration is round-robin.
module sdram_fifo_sched #(
  parameter int unsigned           DATA_DEPTH    = 10,
  parameter int unsigned           BURST_LEN     = 8,
  parameter int unsigned           ADDR_WIDTH    = 24,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = 24'h000100,
  parameter int unsigned           REGION_BURSTS = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 init_done,
  input  logic                                 rd_en,
  input  logic [DATA_DEPTH-1:0]                wr_use_num,
  input  logic [DATA_DEPTH-1:0]                rd_use_num,
  sdram_fifo_sched_if.master                   sdram,
  output logic [$clog2(REGION_BURSTS+1)-1:0]   sdram_fill,
  output logic                                 busy,
  output logic                                 err
);

  localparam int unsigned FILL_W = $clog2(REGION_BURSTS + 1);
  localparam int unsigned CNT_W  = $clog2(BURST_LEN + 1);

  localparam logic [CNT_W-1:0]      BeatLast = CNT_W'(BURST_LEN - 1);
  localparam logic [FILL_W-1:0]     FillMax  = FILL_W'(REGION_BURSTS);
  localparam logic [ADDR_WIDTH-1:0] AddrStep = ADDR_WIDTH'(BURST_LEN);
  localparam logic [ADDR_WIDTH-1:0] AddrEnd  =
      BASE_ADDR + ADDR_WIDTH'(REGION_BURSTS * BURST_LEN);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWr   = 2'd1;
  localparam logic [1:0] StRd   = 2'd2;

  localparam logic LastWr = 1'b0;
  localparam logic LastRd = 1'b1;

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      beat_q, beat_d;
  logic                  last_q, last_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [FILL_W-1:0]     fill_q, fill_d;
  logic                  err_q, err_d;

  logic [DATA_DEPTH-1:0] rd_free;
  logic                  wr_ok, rd_ok, pick_wr;
  logic                  wr_ack, rd_ack;

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
    next_addr = (a + AddrStep == AddrEnd) ? BASE_ADDR : a + AddrStep;
  endfunction

  assign wr_ack = sdram.sdram_wr_ack;
  assign rd_ack = sdram.sdram_rd_ack;

  // Bitwise inversion of the use count is exactly 2^DATA_DEPTH - 1 - rd_use_num.
  assign rd_free = ~rd_use_num;

  assign wr_ok = init_done && (32'(wr_use_num) >= BURST_LEN) && (fill_q < FillMax);
  assign rd_ok = init_done && rd_en && (fill_q != '0) && (32'(rd_free) >= BURST_LEN);

`ifdef SDRAM_WR_PRIORITY_EN
  assign pick_wr = wr_ok;
`else
  assign pick_wr = wr_ok && (!rd_ok || (last_q == LastRd));
`endif

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    last_d    = last_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    fill_d    = fill_q;
    err_d     = err_q;

    case (state_q)
      StIdle: begin
        if (wr_ack || rd_ack) begin
          err_d = 1'b1;
        end
        if (pick_wr) begin
          state_d = StWr;
        end else if (rd_ok) begin
          state_d = StRd;
        end
      end
      StWr: begin
        // A stray read ack (alone or alongside a write ack) never counts as a beat.
        if (rd_ack) begin
          err_d = 1'b1;
        end else if (wr_ack) begin
          if (beat_q == BeatLast) begin
            state_d   = StIdle;
            beat_d    = '0;
            last_d    = LastWr;
            wr_addr_d = next_addr(wr_addr_q);
            fill_d    = fill_q + FILL_W'(1);
          end else begin
            beat_d = beat_q + CNT_W'(1);
          end
        end
      end
      StRd: begin
        if (wr_ack) begin
          err_d = 1'b1;
        end else if (rd_ack) begin
          if (beat_q == BeatLast) begin
            state_d   = StIdle;
            beat_d    = '0;
            last_d    = LastRd;
            rd_addr_d = next_addr(rd_addr_q);
            fill_d    = fill_q - FILL_W'(1);
          end else begin
            beat_d = beat_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
        beat_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      beat_q    <= '0;
      last_q    <= LastRd;
      wr_addr_q <= BASE_ADDR;
      rd_addr_q <= BASE_ADDR;
      fill_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      last_q    <= last_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      fill_q    <= fill_d;
      err_q     <= err_d;
    end
  end

  assign sdram.sdram_wr_req  = (state_q == StWr);
  assign sdram.sdram_rd_req  = (state_q == StRd);
  assign sdram.sdram_wr_addr = wr_addr_q;
  assign sdram.sdram_rd_addr = rd_addr_q;
  assign sdram_fill          = fill_q;
  assign busy                = (state_q != StIdle);
  assign err                 = err_q;

endmodule

// File: tb/tb_sdram_fifo_sched.sv
// Scoreboard bench for sdram_fifo_sched: expected burst requests are queued by the stimulus
// and popped by a monitor on every rising request; state checks are made inline.
module tb_sdram_fifo_sched;

  typedef struct packed {
    logic        is_wr;
    logic [23:0] addr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       init_done;
  logic       rd_en;
  logic [9:0] wr_use_num;
  logic [9:0] rd_use_num;
  logic [2:0] sdram_fill;
  logic       busy;
  logic       err;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t q[$];

  sdram_fifo_sched_if #(.ADDR_WIDTH(24)) bus ();

  sdram_fifo_sched #(
    .DATA_DEPTH   (10),
    .BURST_LEN    (8),
    .ADDR_WIDTH   (24),
    .BASE_ADDR    (24'h000100),
    .REGION_BURSTS(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .init_done (init_done),
    .rd_en     (rd_en),
    .wr_use_num(wr_use_num),
    .rd_use_num(rd_use_num),
    .sdram     (bus),
    .sdram_fill(sdram_fill),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_req(input logic is_wr, input logic [23:0] addr);
    exp_t e;
    e.is_wr = is_wr;
    e.addr  = addr;
    q.push_back(e);
  endtask

  // Waits (bounded) for the request, then acks 'beats' consecutive cycles.
  task automatic serve(input logic is_wr, input int beats);
    int waited = 0;
    while (!(is_wr ? bus.sdram_wr_req : bus.sdram_rd_req) && waited < 20) begin
      tick();
      waited++;
    end
    check("req_timeout", 32'(is_wr ? bus.sdram_wr_req : bus.sdram_rd_req), 32'd1);
    for (int i = 0; i < beats; i++) begin
      if (is_wr) bus.sdram_wr_ack = 1'b1;
      else       bus.sdram_rd_ack = 1'b1;
      tick();
    end
    bus.sdram_wr_ack = 1'b0;
    bus.sdram_rd_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    init_done  = 1'b1;
    rd_en      = 1'b0;
    wr_use_num = '0;
    rd_use_num = '0;
    bus.sdram_wr_ack = 1'b0;
    bus.sdram_rd_ack = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic monitor();
    logic pw = 1'b0;
    logic pr = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        pw = 1'b0;
        pr = 1'b0;
      end else begin
        if ((bus.sdram_wr_req && !pw) || (bus.sdram_rd_req && !pr)) begin
          check("req_expected", 32'(q.size() != 0), 32'd1);
          if (q.size() != 0) begin
            e = q.pop_front();
            check("req_is_wr", 32'(bus.sdram_wr_req), 32'(e.is_wr));
            check("req_addr", 32'(bus.sdram_wr_req ? bus.sdram_wr_addr : bus.sdram_rd_addr),
                  32'(e.addr));
          end
        end
        pw = bus.sdram_wr_req;
        pr = bus.sdram_rd_req;
      end
    end
  endtask

`ifdef SDRAM_WR_PRIORITY_EN
  localparam int          ArbN = 5;
  localparam logic [4:0]  ArbWr = 5'b01111;
  localparam logic [23:0] ArbAddr [5] = '{24'h100, 24'h108, 24'h110, 24'h118, 24'h100};
  localparam logic [23:0] PostFill = 24'd3;
  localparam logic [23:0] PostWrAddr = 24'h100;
`else
  localparam int          ArbN = 4;
  localparam logic [4:0]  ArbWr = 5'b00101;
  localparam logic [23:0] ArbAddr [5] = '{24'h100, 24'h100, 24'h108, 24'h108, 24'h000};
  localparam logic [23:0] PostFill = 24'd0;
  localparam logic [23:0] PostWrAddr = 24'h110;
`endif

  initial begin
    logic [4:0] arb_wr;
    arb_wr = ArbWr;
    rst        = 1'b1;
    init_done  = 1'b0;
    rd_en      = 1'b0;
    wr_use_num = '0;
    rd_use_num = '0;
    bus.sdram_wr_ack = 1'b0;
    bus.sdram_rd_ack = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) tick();

    check("rst_wr_req",  32'(bus.sdram_wr_req), 32'd0);
    check("rst_rd_req",  32'(bus.sdram_rd_req), 32'd0);
    check("rst_wr_addr", 32'(bus.sdram_wr_addr), 32'h100);
    check("rst_rd_addr", 32'(bus.sdram_rd_addr), 32'h100);
    check("rst_fill",    32'(sdram_fill), 32'd0);
    check("rst_busy",    32'(busy), 32'd0);
    check("rst_err",     32'(err), 32'd0);
    rst = 1'b0;

    // Init gating: any request here is unexpected and caught by the monitor.
    wr_use_num = 10'd20;
    rd_en      = 1'b1;
    repeat (50) tick();
    check("init_gate_busy", 32'(busy), 32'd0);

    // Single write burst.
    init_done  = 1'b1;
    rd_en      = 1'b0;
    wr_use_num = 10'd8;
    expect_req(1'b1, 24'h100);
    serve(1'b1, 8);
    wr_use_num = 10'd0;
    check("single_req_drop", 32'(bus.sdram_wr_req), 32'd0);
    check("single_wr_addr",  32'(bus.sdram_wr_addr), 32'h108);
    check("single_fill",     32'(sdram_fill), 32'd1);
    check("single_busy",     32'(busy), 32'd0);

    // Wrap and full.
    wr_use_num = 10'd20;
    expect_req(1'b1, 24'h108);
    serve(1'b1, 8);
    expect_req(1'b1, 24'h110);
    serve(1'b1, 8);
    expect_req(1'b1, 24'h118);
    serve(1'b1, 8);
    check("wrap_wr_addr", 32'(bus.sdram_wr_addr), 32'h100);
    check("wrap_fill",    32'(sdram_fill), 32'd4);
    repeat (10) tick();
    check("full_blocks_busy", 32'(busy), 32'd0);
    rd_en = 1'b1;
    expect_req(1'b0, 24'h100);
    serve(1'b0, 8);
    rd_en = 1'b0;
    check("full_rd_fill", 32'(sdram_fill), 32'd3);
    expect_req(1'b1, 24'h100);
    serve(1'b1, 8);
    wr_use_num = 10'd0;
    check("refill_fill",    32'(sdram_fill), 32'd4);
    check("refill_wr_addr", 32'(bus.sdram_wr_addr), 32'h108);
    check("refill_rd_addr", 32'(bus.sdram_rd_addr), 32'h108);

    // Read gating.
    do_reset();
    rd_en = 1'b1;
    repeat (20) tick();
    check("rd_empty_busy", 32'(busy), 32'd0);
    rd_en      = 1'b0;
    wr_use_num = 10'd20;
    expect_req(1'b1, 24'h100);
    serve(1'b1, 8);
    expect_req(1'b1, 24'h108);
    serve(1'b1, 8);
    wr_use_num = 10'd0;
    check("rd_gate_fill", 32'(sdram_fill), 32'd2);
    rd_en      = 1'b1;
    rd_use_num = 10'd1020;
    repeat (20) tick();
    check("rd_space_busy", 32'(busy), 32'd0);
    rd_use_num = 10'd1000;
    expect_req(1'b0, 24'h100);
    serve(1'b0, 8);
    rd_en = 1'b0;
    check("rd_done_fill", 32'(sdram_fill), 32'd1);

    // Arbitration with both sides kept eligible.
    do_reset();
    wr_use_num = 10'd20;
    rd_use_num = 10'd0;
    rd_en      = 1'b1;
    for (int i = 0; i < ArbN; i++) begin
      expect_req(arb_wr[i], ArbAddr[i]);
      serve(arb_wr[i], 8);
    end
    wr_use_num = 10'd0;
    rd_en      = 1'b0;
    check("arb_fill", 32'(sdram_fill), 32'(PostFill));

    // Stray ack in idle.
    tick();
    bus.sdram_wr_ack = 1'b1;
    tick();
    bus.sdram_wr_ack = 1'b0;
    check("err_set",     32'(err), 32'd1);
    check("err_fill",    32'(sdram_fill), 32'(PostFill));
    check("err_wr_addr", 32'(bus.sdram_wr_addr), 32'(PostWrAddr));
    check("err_busy",    32'(busy), 32'd0);

    // Reset in the middle of a write burst.
    wr_use_num = 10'd20;
    expect_req(1'b1, PostWrAddr);
    serve(1'b1, 3);
    rst = 1'b1;
    #1;
    check("mid_rst_req",     32'(bus.sdram_wr_req), 32'd0);
    check("mid_rst_err",     32'(err), 32'd0);
    check("mid_rst_wr_addr", 32'(bus.sdram_wr_addr), 32'h100);
    check("mid_rst_rd_addr", 32'(bus.sdram_rd_addr), 32'h100);
    check("mid_rst_fill",    32'(sdram_fill), 32'd0);
    check("mid_rst_busy",    32'(busy), 32'd0);
    wr_use_num = 10'd0;
    tick();
    rst = 1'b0;

    repeat (5) tick();
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
